// File: rtl/arith_pkg.sv
// Shared types and op-decoding helpers for the chunked add/subtract unit.
// Contents:
//   arith_op_t    - operation encoding (ADD, ADDC, SUB, SUBC)
//   arith_state_t - control FSM states (IDLE, BUSY, DONE)
//   op_is_sub     - true for SUB/SUBC (operand b is inverted)
//   op_cin        - initial carry-in for an op given the stored flag
package arith_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    ADDC = 2'd1,
    SUB  = 2'd2,
    SUBC = 2'd3
  } arith_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arith_state_t;

  // Bit positions inside the op code used by the decoder.
  localparam int unsigned OP_SUB_BIT   = 1;
  localparam int unsigned OP_CARRY_BIT = 0;

  function automatic logic op_is_sub(input logic [1:0] op);
    return op[OP_SUB_BIT];
  endfunction

  // Subtraction is a + ~b + 1, so a stored borrow enters as its inverse.
  function automatic logic op_cin(input logic [1:0] op, input logic flag);
    logic cin;
    case (arith_op_t'(op))
      ADD:     cin = 1'b0;
      ADDC:    cin = flag;
      SUB:     cin = 1'b1;
      SUBC:    cin = ~flag;
      default: cin = 1'b0;
    endcase
    return cin;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in/out, shared across all chunks.
// Ports:
//   a, b  - CHUNK-bit addends
//   cin   - carry in
//   sum   - CHUNK-bit sum
//   cout  - carry out
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total_s;

  assign total_s   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum       = total_s[CHUNK-1:0];
  assign cout      = total_s[CHUNK];

endmodule

// File: rtl/chunked_arith_unit.sv
// Multi-cycle ADD/ADDC/SUB/SUBC unit processing CHUNK bits per clock, LSB
// chunk first, with a persistent carry/borrow flag for multi-word arithmetic.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (op, a, b sampled on accept)
//   op                    - 0=ADD 1=ADDC 2=SUB 3=SUBC
//   c_load/c_load_val     - load stored carry flag (honoured in IDLE only)
//   res_valid/res_ready   - result handshake
//   result                - WIDTH-bit sum/difference
//   c_out v_out z_out n_out - carry/borrow, overflow, zero, negative
//   c_flag                - stored carry/borrow flag
module chunked_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_load,
  input  logic             c_load_val,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out,
  output logic             c_flag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  arith_state_t     state_r, state_next_s;
  logic [WIDTH-1:0] a_r, b_r, acc_r, acc_next_s, result_r;
  logic [KW-1:0]    k_r;
  logic             sub_r, carry_r;
  logic             c_out_r, v_out_r, z_out_r, n_out_r, c_flag_r;
  logic             accept_s, last_s, flag_eff_s, c_final_s, v_final_s;
  logic [CHUNK-1:0] chunk_a_s, chunk_b_s, chunk_sum_s;
  logic             chunk_cout_s;

  // Handshake outputs are pure decodes of the state register.
  assign req_ready  = (state_r == IDLE);
  assign res_valid  = (state_r == DONE);
  assign accept_s   = req_valid & (state_r == IDLE);
  assign last_s     = (k_r == LAST_K);
  // A coincident c_load overrides the stored flag for the accepted op.
  assign flag_eff_s = c_load ? c_load_val : c_flag_r;

  assign chunk_a_s  = a_r[CHUNK*int'(k_r) +: CHUNK];
  assign chunk_b_s  = b_r[CHUNK*int'(k_r) +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (chunk_a_s),
    .b    (chunk_b_s),
    .cin  (carry_r),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s)
  );

  // Working sum with the current chunk merged in.
  always_comb begin
    acc_next_s = acc_r;
    acc_next_s[CHUNK*int'(k_r) +: CHUNK] = chunk_sum_s;
  end

  // Flags for the final chunk; b_r already holds the effective (inverted) operand.
  assign c_final_s = sub_r ? ~chunk_cout_s : chunk_cout_s;
  assign v_final_s = (~a_r[WIDTH-1] & ~b_r[WIDTH-1] &  acc_next_s[WIDTH-1]) |
                     ( a_r[WIDTH-1] &  b_r[WIDTH-1] & ~acc_next_s[WIDTH-1]);

  // Next-state logic for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = BUSY;
        else          state_next_s = IDLE;
      end
      BUSY: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = BUSY;
      end
      DONE: begin
        if (res_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Operand capture, chunk iteration, result/flag registers and stored carry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      result_r <= '0;
      k_r      <= '0;
      sub_r    <= 1'b0;
      carry_r  <= 1'b0;
      c_out_r  <= 1'b0;
      v_out_r  <= 1'b0;
      z_out_r  <= 1'b0;
      n_out_r  <= 1'b0;
      c_flag_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (c_load) c_flag_r <= c_load_val;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= op_is_sub(op) ? ~b : b;
            sub_r   <= op_is_sub(op);
            carry_r <= op_cin(op, flag_eff_s);
            k_r     <= '0;
            acc_r   <= '0;
          end
        end
        BUSY: begin
          acc_r   <= acc_next_s;
          carry_r <= chunk_cout_s;
          k_r     <= k_r + KW'(1);
          if (last_s) begin
            result_r <= acc_next_s;
            c_out_r  <= c_final_s;
            v_out_r  <= v_final_s;
            z_out_r  <= (acc_next_s == '0);
            n_out_r  <= acc_next_s[WIDTH-1];
            c_flag_r <= c_final_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;
  assign c_out  = c_out_r;
  assign v_out  = v_out_r;
  assign z_out  = z_out_r;
  assign n_out  = n_out_r;
  assign c_flag = c_flag_r;

endmodule
